cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 104 ++++++++++
 tb/tb_cdb_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: two-slot round-robin common data bus arbiter with registered grants.
// Optional starvation guard enabled by defining CDB_ARB_STARVATION_GUARD_EN.
module cdb_arbiter #(
    parameter int REQUESTERS   = 5,
    parameter int BUSES        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          flush,
    input  logic [REQUESTERS-1:0]                         req,
    output logic [REQUESTERS-1:0]                         grant,
    output logic [REQUESTERS-1:0]                         grant_bus,
    output logic [BUSES-1:0]                              bus_valid,
    output logic [BUSES-1:0][$clog2(REQUESTERS)-1:0]      bus_owner
);
    localparam int W = $clog2(REQUESTERS);

    if (BUSES != 2 || REQUESTERS < 2 || STARVE_LIMIT < 1) begin : g_bad_cfg
        $error("cdb_arbiter: unsupported parameter set");
    end

    logic [W-1:0]            ptr, ptr_nxt, own0, own1, idx, last;
    logic                    v0, v1;
    logic [REQUESTERS-1:0]   gnt_n, gbus_n, starved;

`ifdef CDB_ARB_STARVATION_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [REQUESTERS-1:0][CW-1:0] cnt;

    always_comb begin
        starved = '0;
        for (int i = 0; i < REQUESTERS; i++)
            starved[i] = cnt[i] == CW'(STARVE_LIMIT);
    end

    always_ff @(posedge clock) begin
        if (reset || flush)
            cnt <= '0;
        else
            for (int i = 0; i < REQUESTERS; i++)
                if (gnt_n[i])
                    cnt[i] <= '0;
                else if (req[i] && !starved[i])
                    cnt[i] <= cnt[i] + 1'b1;
    end
`else
    assign starved = '0;
`endif

    // A starved unit (lowest index) claims bus 0; round-robin fills the remaining slots.
    always_comb begin
        v0 = 1'b0;
        v1 = 1'b0;
        own0 = '0;
        own1 = '0;
        idx = '0;
        gnt_n = '0;
        gbus_n = '0;
        for (int i = 0; i < REQUESTERS; i++)
            if (req[i] && starved[i] && !v0) begin
                v0 = 1'b1;
                own0 = W'(i);
            end
        for (int k = 0; k < REQUESTERS; k++) begin
            idx = W'((int'(ptr) + k) % REQUESTERS);
            if (req[idx] && !v1 && !(v0 && own0 == idx)) begin
                if (!v0) begin
                    v0 = 1'b1;
                    own0 = idx;
                end else begin
                    v1 = 1'b1;
                    own1 = idx;
                end
            end
        end
        if (v0) gnt_n[own0] = 1'b1;
        if (v1) begin
            gnt_n[own1] = 1'b1;
            gbus_n[own1] = 1'b1;
        end
        last = v1 ? own1 : own0;
        ptr_nxt = !v0 ? ptr : (last == W'(REQUESTERS - 1)) ? '0 : last + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            grant <= '0;
            grant_bus <= '0;
            bus_valid <= '0;
            bus_owner <= '0;
        end else begin
            grant <= gnt_n;
            grant_bus <= gbus_n;
            bus_valid <= {v1, v0};
            bus_owner[0] <= own0;
            bus_owner[1] <= own1;
        end
        if (reset)
            ptr <= '0;
        else if (!flush)
            ptr <= ptr_nxt;
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter; expected outputs pushed at drive time, popped one cycle later.
module tb_cdb_arbiter;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic [4:0] req = '0;
    logic [4:0] grant, grant_bus;
    logic [1:0] bus_valid;
    logic [1:0][2:0] bus_owner;

    typedef logic [17:0] out_t;
    out_t sb[$];
    out_t e;
    int checks = 0;
    int failures = 0;
    int mptr = 0;
    int mcnt[5];

    cdb_arbiter #(.REQUESTERS(5), .BUSES(2), .STARVE_LIMIT(2)) dut (
        .clock(clock), .reset(reset), .flush(flush), .req(req),
        .grant(grant), .grant_bus(grant_bus), .bus_valid(bus_valid), .bus_owner(bus_owner)
    );

    always #5 clock = ~clock;

    function automatic out_t obs();
        return {grant, grant_bus, bus_valid, bus_owner};
    endfunction

    // Independent reference: scan from mptr, fill bus 0 then bus 1.
    task automatic drive(input logic [4:0] r, input logic f, input logic rs);
        logic [4:0] g, gb;
        logic [2:0] o0, o1;
        int n, lst;
        req = r;
        flush = f;
        reset = rs;
        g = '0; gb = '0; o0 = '0; o1 = '0; n = 0;
        if (!rs && !f) begin
`ifdef CDB_ARB_STARVATION_GUARD_EN
            for (int i = 0; i < 5; i++)
                if (n == 0 && r[i] && mcnt[i] == 2) begin
                    g[i] = 1'b1; o0 = 3'(i); n = 1;
                end
`endif
            for (int k = 0; k < 5; k++) begin
                int i;
                i = (mptr + k) % 5;
                if (r[i] && !g[i] && n < 2) begin
                    g[i] = 1'b1;
                    if (n == 0) o0 = 3'(i);
                    else begin o1 = 3'(i); gb[i] = 1'b1; end
                    n++;
                end
            end
        end
        for (int i = 0; i < 5; i++)
            if (rs || f || g[i]) mcnt[i] = 0;
            else if (r[i] && mcnt[i] < 2) mcnt[i]++;
        lst = (n == 2) ? int'(o1) : int'(o0);
        if (rs) mptr = 0;
        else if (!f && n > 0) mptr = (lst + 1) % 5;
        sb.push_back({g, gb, n == 2, n >= 1, o1, o0});
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        drive(5'b11111, 0, 1);
        drive(5'b11111, 0, 1);
        e = sb.pop_front(); e = sb.pop_front();
        checks++;
        if (obs() !== 18'd0 || obs() !== e) begin
            failures++; $display("FAIL reset_state: got %h want %h", obs(), 18'd0);
        end
        drive(5'b11111, 0, 0);
        e = sb.pop_front();
        checks++;
        if (grant !== 5'b00011 || bus_owner !== {3'd1, 3'd0} || obs() !== e) begin
            failures++; $display("FAIL reset_first_grant: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_rotation;
        logic [4:0] want[3];
        want[0] = 5'b00011; want[1] = 5'b01100; want[2] = 5'b10001;
        drive(5'b00000, 0, 1);
        e = sb.pop_front();
        for (int c = 0; c < 3; c++) begin
            drive(5'b11111, 0, 0);
            e = sb.pop_front();
            checks++;
            if (grant !== want[c] || bus_valid !== 2'b11 || obs() !== e) begin
                failures++; $display("FAIL rotation_%0d: got %h want %h", c, obs(), e);
            end
        end
        checks++;
        if (bus_owner !== {3'd0, 3'd4}) begin
            failures++; $display("FAIL rotation_owner: got %h want %h", bus_owner, {3'd0, 3'd4});
        end
        drive(5'b11111, 0, 0);
        e = sb.pop_front();
        checks++;
        if (grant !== 5'b00110 || obs() !== e) begin
            failures++; $display("FAIL rotation_ptr: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_single_idle;
        drive(5'b00100, 0, 0);
        e = sb.pop_front();
        checks++;
        if (grant !== 5'b00100 || grant_bus !== 5'b0 || bus_valid !== 2'b01 || bus_owner[0] !== 3'd2 || obs() !== e) begin
            failures++; $display("FAIL single: got %h want %h", obs(), e);
        end
        drive(5'b00000, 0, 0);
        e = sb.pop_front();
        checks++;
        if (grant !== 5'b0 || bus_valid !== 2'b0 || obs() !== e) begin
            failures++; $display("FAIL idle: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_flush;
        drive(5'b00110, 1, 0);
        e = sb.pop_front();
        checks++;
        if (grant !== 5'b0 || bus_valid !== 2'b0 || obs() !== e) begin
            failures++; $display("FAIL flush_gap: got %h want %h", obs(), e);
        end
        drive(5'b00110, 0, 0);
        e = sb.pop_front();
        checks++;
        if (grant !== 5'b00110 || obs() !== e) begin
            failures++; $display("FAIL flush_resume: got %h want %h", obs(), e);
        end
        drive(5'b11111, 1, 1);
        e = sb.pop_front();
        drive(5'b11111, 0, 0);
        e = sb.pop_front();
        checks++;
        if (grant !== 5'b00011 || obs() !== e) begin
            failures++; $display("FAIL reset_over_flush: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_back_to_back;
        drive(5'b00000, 0, 1);
        e = sb.pop_front();
        for (int c = 0; c < 3; c++) begin
            drive(5'b01000, 0, 0);
            e = sb.pop_front();
            checks++;
            if (grant !== 5'b01000 || bus_owner[0] !== 3'd3 || obs() !== e) begin
                failures++; $display("FAIL b2b_%0d: got %h want %h", c, obs(), e);
            end
        end
        drive(5'b00000, 0, 0);
        e = sb.pop_front();
        checks++;
        if (grant !== 5'b0 || obs() !== e) begin
            failures++; $display("FAIL b2b_drop: got %h want %h", obs(), e);
        end
        drive(5'b11111, 0, 0);
        e = sb.pop_front();
        drive(5'b11111, 0, 1);
        e = sb.pop_front();
        checks++;
        if (grant !== 5'b0 || obs() !== e) begin
            failures++; $display("FAIL mid_reset: got %h want %h", obs(), e);
        end
    endtask

    task automatic test_starvation;
        logic seen;
        seen = 1'b0;
        drive(5'b00000, 0, 1);
        e = sb.pop_front();
        for (int c = 0; c < 3; c++) begin
            drive(5'b11111, 0, 0);
            e = sb.pop_front();
            seen = seen | grant[4];
            checks++;
            if (obs() !== e) begin
                failures++; $display("FAIL starve_%0d: got %h want %h", c, obs(), e);
            end
        end
        checks++;
        if (seen !== 1'b1 || grant !== 5'b10001 || bus_owner[0] !== 3'd4) begin
            failures++; $display("FAIL starve_grant: got seen=%b grant=%b want unit4 on bus0", seen, grant);
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 200; c++) begin
            drive(5'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++; $display("FAIL random_%0d: got %h want %h", c, obs(), e);
            end
        end
    endtask

    initial begin
        foreach (mcnt[i]) mcnt[i] = 0;
        test_reset;
        test_rotation;
        test_single_idle;
        test_flush;
        test_back_to_back;
        test_starvation;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
